// File: rtl/drone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drone_pkg
// Purpose  : Shared types, motor encodings and one-hot helpers for the
//            drone_ctrl_n controller and its scheduler.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package drone_pkg;

  // Helpers operate on a fixed-width vector; callers zero-extend into it.
  localparam int MAX_FLOORS = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DROP      = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_UP   = 2'b01;
  localparam logic [1:0] MOT_DN   = 2'b10;

  // True when exactly one bit is set.
  function automatic logic onehot_valid(input logic [MAX_FLOORS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Index of the set bit; OR-reduction keeps it a flat mux tree.
  function automatic logic [4:0] onehot_to_idx(input logic [MAX_FLOORS-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (v[i]) idx = idx | i[4:0];
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drone_sched.sv
`default_nettype none
// ============================================================================
// Module   : drone_sched
// Purpose  : Combinational SCAN scheduler. Reports whether requests exist
//            above/below/at the current floor and the direction to take next.
// Ports    : pending_i  - latched requests
//            pos_i      - current floor index
//            dir_i      - current direction (1 up, 0 down)
//            any_above_o, any_below_o, here_o, next_dir_o
// Revision : 1.0 - initial release
// ============================================================================
module drone_sched
  import drone_pkg::*;
#(
  parameter int NFLOORS = 8,
  localparam int PW = $clog2(NFLOORS)
) (
  input  logic [NFLOORS-1:0] pending_i,
  input  logic [PW-1:0]      pos_i,
  input  logic               dir_i,
  output logic               any_above_o,
  output logic               any_below_o,
  output logic               here_o,
  output logic               next_dir_o
);

  always_comb begin
    any_above_o = 1'b0;
    any_below_o = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (pending_i[i] && (i > int'(pos_i))) any_above_o = 1'b1;
      if (pending_i[i] && (i < int'(pos_i))) any_below_o = 1'b1;
    end
    here_o = pending_i[pos_i];
    // Keep heading up while work remains above, unless we are going down
    // and there is still work below; with nothing pending keep dir.
    if (any_above_o && (dir_i || !any_below_o)) begin
      next_dir_o = 1'b1;
    end else if (any_below_o) begin
      next_dir_o = 1'b0;
    end else begin
      next_dir_o = dir_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/drone_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : drone_ctrl_n
// Purpose  : N-floor drone controller. Latches calls, serves them in SCAN
//            order, drives the motor command and a timed drop pulse, and
//            flags sensor/travel faults (sticky until reset).
// Ports    : clk, rst          - clock, synchronous active-high reset
//            call_i            - call buttons (level)
//            floor_sense_i     - floor sensors (one-hot at a floor, else 0)
//            motor_o           - 00 stop, 01 up, 10 down
//            drop_o            - payload release pulse
//            pos_o             - last floor sensed
//            pending_o         - outstanding requests
//            fault_o           - sticky fault flag
// Revision : 1.0 - initial release
// ============================================================================
module drone_ctrl_n
  import drone_pkg::*;
#(
  parameter int NFLOORS      = 8,
  parameter int DROP_CYCLES  = 16,
  parameter int MOVE_TIMEOUT = 1024,
  localparam int PW = $clog2(NFLOORS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] call_i,
  input  logic [NFLOORS-1:0] floor_sense_i,
  output logic [1:0]         motor_o,
  output logic               drop_o,
  output logic [PW-1:0]      pos_o,
  output logic [NFLOORS-1:0] pending_o,
  output logic               fault_o
);

  localparam int c_drop_w = $clog2(DROP_CYCLES + 1);
  localparam int c_tmo_w  = $clog2(MOVE_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [NFLOORS-1:0]  pending_q, pending_d;
  logic [c_drop_w-1:0] drop_cnt_q, drop_cnt_d;
  logic [c_tmo_w-1:0]  move_cnt_q, move_cnt_d;

  logic [MAX_FLOORS-1:0] w_fs_ext;
  logic                  w_fs_valid;
  logic                  w_fs_multi;
  logic [PW-1:0]         w_fs_idx;
  logic                  w_new_hit;
  logic                  w_hit_pend;
  logic                  w_in_move;
  logic                  w_drop_last;
  logic [NFLOORS-1:0]    w_clr;
  logic                  w_any_above, w_any_below, w_here, w_next_dir;

  assign w_fs_ext   = MAX_FLOORS'(floor_sense_i);
  assign w_fs_valid = onehot_valid(w_fs_ext);
  assign w_fs_multi = (w_fs_ext != '0) && !w_fs_valid;
  assign w_fs_idx   = PW'(onehot_to_idx(w_fs_ext));
  // A sensor still reporting the floor we just left is not a new arrival.
  assign w_new_hit  = w_fs_valid && (w_fs_idx != pos_q);
  assign w_hit_pend = pending_q[w_fs_idx];
  assign w_in_move  = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN);
  assign w_drop_last = (state_q == ST_DROP) &&
                       (drop_cnt_q == c_drop_w'(DROP_CYCLES - 1));
  assign w_clr      = w_drop_last ? (NFLOORS'(1) << pos_q) : '0;

  drone_sched #(
    .NFLOORS (NFLOORS)
  ) u_sched (
    .pending_i   (pending_q),
    .pos_i       (pos_q),
    .dir_i       (dir_q),
    .any_above_o (w_any_above),
    .any_below_o (w_any_below),
    .here_o      (w_here),
    .next_dir_o  (w_next_dir)
  );

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b1;
      pos_q      <= '0;
      pending_q  <= '0;
      drop_cnt_q <= '0;
      move_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
      move_cnt_q <= move_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pos_d     = w_fs_valid ? w_fs_idx : pos_q;
    pending_d = (pending_q | call_i) & ~w_clr;
    // Counters run only inside their own state, so they are zero on entry.
    drop_cnt_d = ((state_q == ST_DROP) && !w_drop_last) ? drop_cnt_q + 1'b1 : '0;
    move_cnt_d = (w_in_move && !w_new_hit) ? move_cnt_q + 1'b1 : '0;

    case (state_q)
      ST_IDLE: begin
        if (w_here) begin
          state_d = ST_DROP;
        end else if (w_any_above || w_any_below) begin
          dir_d   = w_next_dir;
          state_d = w_next_dir ? ST_MOVE_UP : ST_MOVE_DOWN;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (w_new_hit) begin
          if (w_hit_pend) begin
            state_d = ST_DROP;
          end else if (((state_q == ST_MOVE_UP) && (w_fs_idx == PW'(NFLOORS - 1))) ||
                       ((state_q == ST_MOVE_DOWN) && (w_fs_idx == '0))) begin
            state_d = ST_FAULT;
          end
        end else if (move_cnt_q == c_tmo_w'(MOVE_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
        end
      end
      ST_DROP: begin
        if (w_drop_last) state_d = ST_IDLE;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    // Conflicting sensors override everything else.
    if (w_fs_multi) state_d = ST_FAULT;
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    motor_o = MOT_STOP;
    drop_o  = 1'b0;
    fault_o = 1'b0;
    case (state_q)
      ST_MOVE_UP:   motor_o = MOT_UP;
      ST_MOVE_DOWN: motor_o = MOT_DN;
      ST_DROP:      drop_o  = 1'b1;
      ST_FAULT:     fault_o = 1'b1;
      default:      motor_o = MOT_STOP;
    endcase
  end

  assign pos_o     = pos_q;
  assign pending_o = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_drone_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_drone_ctrl_n
// Purpose  : Self-checking bench for drone_ctrl_n. Directed stimulus pushes
//            the expected sequence of output changes into a queue; a monitor
//            pops and compares each time motor/drop/fault change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drone_ctrl_n;

  localparam int c_nf   = 8;
  localparam int c_drop = 16;
  localparam int c_tmo  = 1024;

  logic            clk;
  logic            rst;
  logic [c_nf-1:0] call_i;
  logic [c_nf-1:0] floor_sense_i;
  logic [1:0]      motor_o;
  logic            drop_o;
  logic [2:0]      pos_o;
  logic [c_nf-1:0] pending_o;
  logic            fault_o;

  drone_ctrl_n #(
    .NFLOORS      (c_nf),
    .DROP_CYCLES  (c_drop),
    .MOVE_TIMEOUT (c_tmo)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .call_i        (call_i),
    .floor_sense_i (floor_sense_i),
    .motor_o       (motor_o),
    .drop_o        (drop_o),
    .pos_o         (pos_o),
    .pending_o     (pending_o),
    .fault_o       (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] motor;
    logic       drop;
    logic       fault;
    logic [2:0] pos;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  logic mon_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] m, input logic d, input logic f, input int p);
    ev_t e;
    e.motor = m; e.drop = d; e.fault = f; e.pos = 3'(p);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    call_i = '0;
    floor_sense_i = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Walk the sensors from one floor to another, one cycle per floor with a
  // gap cycle between floors; the destination sensor is left asserted.
  task automatic travel(input int from, input int to);
    int step;
    step = (to > from) ? 1 : -1;
    for (int f = from + step; f != to + step; f += step) begin
      floor_sense_i = c_nf'(1) << f;
      tick();
      if (f != to) begin
        floor_sense_i = '0;
        tick();
      end
    end
  endtask

  task automatic wait_drop_done();
    int n;
    n = 0;
    while (drop_o && n < 64) begin
      tick();
      n++;
    end
    chk("drop_end_bound", int'(drop_o), 0);
  endtask

  task automatic wait_motor();
    int n;
    n = 0;
    while (motor_o == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk("motor_start_bound", int'(motor_o != 2'b00), 1);
  endtask

  // Monitor: compares every change of motor/drop/fault against the queue
  // and measures the length of each uninterrupted drop pulse.
  logic [3:0] prev_out;
  int         drop_run = 0;
  logic       drop_abort = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t act;
      ev_t exp;
      if (rst && drop_run != 0) drop_abort = 1'b1;
      if (drop_o) begin
        drop_run++;
      end else if (drop_run != 0) begin
        if (!drop_abort) chk("drop_len", drop_run, c_drop);
        drop_run = 0;
        drop_abort = 1'b0;
      end
      if ({motor_o, drop_o, fault_o} != prev_out) begin
        act.motor = motor_o; act.drop = drop_o; act.fault = fault_o; act.pos = pos_o;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", int'(act), -1);
        end else begin
          exp = exp_q.pop_front();
          chk("event{motor,drop,fault,pos}", int'(act), int'(exp));
        end
        prev_out = {motor_o, drop_o, fault_o};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    call_i = '0;
    floor_sense_i = '0;
    tick();
    tick();
    chk("rst_motor",   int'(motor_o),   0);
    chk("rst_drop",    int'(drop_o),    0);
    chk("rst_pos",     int'(pos_o),     0);
    chk("rst_pending", int'(pending_o), 0);
    chk("rst_fault",   int'(fault_o),   0);
    rst = 1'b0;
    prev_out = 4'b0000;
    mon_en = 1'b1;

    // Single call up to floor 5.
    push_ev(2'b01, 1'b0, 1'b0, 0);
    push_ev(2'b00, 1'b1, 1'b0, 5);
    push_ev(2'b00, 1'b0, 1'b0, 5);
    call_i = 8'b0010_0000;
    tick();
    call_i = '0;
    chk("t1_pending_t1", int'(pending_o), 8'h20);
    chk("t1_motor_t1", int'(motor_o), 0);
    tick();
    chk("t1_motor_t2", int'(motor_o), 1);
    travel(0, 5);
    chk("t1_drop_on_hit", int'({motor_o, drop_o}), 3'b001);
    chk("t1_pos", int'(pos_o), 5);
    wait_drop_done();
    chk("t1_pending_clear", int'(pending_o), 0);

    // SCAN: stop at 3 going up, then 6 before reversing to 1.
    do_reset();
    push_ev(2'b01, 1'b0, 1'b0, 0);
    push_ev(2'b00, 1'b1, 1'b0, 3);
    push_ev(2'b00, 1'b0, 1'b0, 3);
    push_ev(2'b01, 1'b0, 1'b0, 3);
    push_ev(2'b00, 1'b1, 1'b0, 6);
    push_ev(2'b00, 1'b0, 1'b0, 6);
    push_ev(2'b10, 1'b0, 1'b0, 6);
    push_ev(2'b00, 1'b1, 1'b0, 1);
    push_ev(2'b00, 1'b0, 1'b0, 1);
    call_i = 8'b0000_1000;
    tick();
    call_i = '0;
    tick();
    travel(0, 3);
    chk("t2_drop_at3", int'(drop_o), 1);
    call_i = 8'b0100_0010;
    tick();
    call_i = '0;
    wait_drop_done();
    chk("t2_idle_gap", int'(motor_o), 0);
    chk("t2_pending_16", int'(pending_o), 8'h42);
    wait_motor();
    chk("t2_dir_up", int'(motor_o), 1);
    travel(3, 6);
    wait_drop_done();
    chk("t2_idle_gap2", int'(motor_o), 0);
    wait_motor();
    chk("t2_dir_down", int'(motor_o), 2);
    travel(6, 1);
    chk("t2_drop_at1", int'(drop_o), 1);
    wait_drop_done();
    chk("t2_pending_clear", int'(pending_o), 0);

    // Call at the current floor; repeat call in the final drop cycle.
    do_reset();
    push_ev(2'b00, 1'b1, 1'b0, 2);
    push_ev(2'b00, 1'b0, 1'b0, 2);
    floor_sense_i = 8'b0000_0100;
    tick();
    chk("t3_pos", int'(pos_o), 2);
    call_i = 8'b0000_0100;
    tick();
    call_i = '0;
    tick();
    chk("t3_drop_direct", int'({motor_o, drop_o}), 3'b001);
    repeat (c_drop - 1) tick();
    chk("t3_last_drop_cycle", int'(drop_o), 1);
    call_i = 8'b0000_0100;
    tick();
    call_i = '0;
    chk("t3_drop_off", int'(drop_o), 0);
    chk("t3_call_absorbed", int'(pending_o), 0);
    tick();
    tick();
    chk("t3_still_idle", int'({motor_o, drop_o, pending_o}), 0);

    // Two sensors at once -> sticky fault.
    push_ev(2'b00, 1'b0, 1'b1, 2);
    push_ev(2'b00, 1'b0, 1'b0, 0);
    floor_sense_i = 8'b0011_0000;
    tick();
    chk("t4_fault", int'({motor_o, fault_o}), 3'b001);
    floor_sense_i = '0;
    call_i = 8'b1000_0000;
    repeat (5) tick();
    call_i = '0;
    chk("t4_fault_held", int'({motor_o, fault_o}), 3'b001);
    chk("t4_pending_latches", int'(pending_o), 8'h80);
    do_reset();
    chk("t4_fault_cleared", int'(fault_o), 0);

    // Move timeout with no sensor activity.
    push_ev(2'b01, 1'b0, 1'b0, 0);
    push_ev(2'b00, 1'b0, 1'b1, 0);
    push_ev(2'b00, 1'b0, 1'b0, 0);
    call_i = 8'b1000_0000;
    tick();
    call_i = '0;
    tick();
    chk("t5_moving", int'(motor_o), 1);
    repeat (c_tmo - 1) tick();
    chk("t5_before_timeout", int'({motor_o, fault_o}), 3'b010);
    tick();
    chk("t5_timeout_fault", int'({motor_o, fault_o}), 3'b001);
    do_reset();

    // Reset in the middle of a drop.
    push_ev(2'b00, 1'b1, 1'b0, 0);
    push_ev(2'b00, 1'b0, 1'b0, 0);
    call_i = 8'b0000_0001;
    tick();
    call_i = '0;
    tick();
    chk("t6_drop_on", int'(drop_o), 1);
    call_i = 8'b0001_0000;
    tick();
    call_i = '0;
    repeat (5) tick();
    chk("t6_pending_before", int'(pending_o), 8'h11);
    rst = 1'b1;
    tick();
    chk("t6_rst_outputs", int'({motor_o, drop_o, fault_o}), 0);
    chk("t6_rst_pending", int'(pending_o), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("t6_stays_idle", int'({motor_o, drop_o}), 0);

    chk("event_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
